// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
//
// A transmit FIFO feeds a frame serialiser whose character length
// (5..8 bits), parity (none/even/odd) and stop bits (1/2) are latched
// per frame together with the baud divisor (bit = baud_div_i+1 clocks).
//
// Ports:
//   clock_i            system clock
//   reset_i            asynchronous active-high reset
//   data_write_i       push data_i into the FIFO this cycle
//   data_i             character, low N bits are sent
//   baud_div_i         bit period minus one, in clocks
//   data_bits_i        00=5 01=6 10=7 11=8 data bits
//   parity_i           00=none 01=even 10=odd 11=none
//   stop2_i            0=one stop bit, 1=two stop bits
//   full_thres_i       almost-full threshold
//   data_buffer_full_o level >= full_thres_i
//   fifo_full_o        level == FIFO_DEPTH
//   fifo_level_o       entries held
//   overflow_o         one-cycle pulse when a write is dropped
//   busy_o             frame in progress
//   uart_tx_o          serial line, idle high
module uart_tx_cfg #(
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH),
  parameter int DIV_W      = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             data_write_i,
  input  logic [7:0]       data_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic [1:0]       parity_i,
  input  logic             stop2_i,
  input  logic [AW:0]      full_thres_i,
  output logic             data_buffer_full_o,
  output logic             fifo_full_o,
  output logic [AW:0]      fifo_level_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             uart_tx_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic             ovf_q;

  state_t           state;
  logic [DIV_W-1:0] baud_cnt, div_q;
  logic [1:0]       db_q;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_en_q, par_bit_q, stop2_q, stop_idx, tx_q;

  logic bit_end, frame_done, pop, push;

  // Parity over the N enabled data bits; odd parity inverts the even result.
  function automatic logic frame_parity(input logic [7:0] d,
                                        input logic [1:0] db,
                                        input logic       odd);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, db});
    return (^(d & mask)) ^ odd;
  endfunction

  assign bit_end    = (baud_cnt == div_q);
  assign frame_done = (state == STOP) && bit_end && (stop_idx || !stop2_q);
  // A new frame starts from IDLE or straight out of the last stop bit.
  assign pop        = (level != '0) && ((state == IDLE) || frame_done);
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push       = data_write_i && ((level != DEPTH_L) || pop);

  // FIFO control
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= data_write_i && !push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Frame serialiser
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      div_q     <= '0;
      db_q      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
      tx_q      <= 1'b1;
    end else if (pop) begin
      state     <= START;
      baud_cnt  <= '0;
      div_q     <= baud_div_i;
      db_q      <= data_bits_i;
      par_en_q  <= (parity_i == 2'b01) || (parity_i == 2'b10);
      par_bit_q <= frame_parity(mem[rd_ptr], data_bits_i, parity_i == 2'b10);
      stop2_q   <= stop2_i;
      shreg     <= mem[rd_ptr];
      tx_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shreg[0];
            shreg    <= shreg >> 1;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Last data bit index is N-1 = 4 + data_bits code.
            if (bit_idx == {1'b1, db_q}) begin
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state    <= STOP;
                tx_q     <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            stop_idx <= 1'b0;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop2_q && !stop_idx) stop_idx <= 1'b1;
            else                      state    <= IDLE;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_buffer_full_o = (level >= full_thres_i);
  assign fifo_full_o        = (level == DEPTH_L);
  assign fifo_level_o       = level;
  assign overflow_o         = ovf_q;
  assign busy_o             = (state != IDLE);
  assign uart_tx_o          = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: directed frame table, FIFO/reset sequences
// and randomized frames decoded by a bench-side receiver.
module tb_uart_tx_cfg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_write;
  logic [7:0]       data;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_bits;
  logic [1:0]       parity;
  logic             stop2;
  logic [AW:0]      full_thres;
  logic             data_buffer_full, fifo_full, overflow, busy, uart_tx;
  logic [AW:0]      fifo_level;

  int vecs = 0;
  int errs = 0;

  uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clock_i(clk), .reset_i(rst), .data_write_i(data_write), .data_i(data),
    .baud_div_i(baud_div), .data_bits_i(data_bits), .parity_i(parity),
    .stop2_i(stop2), .full_thres_i(full_thres),
    .data_buffer_full_o(data_buffer_full), .fifo_full_o(fifo_full),
    .fifo_level_o(fifo_level), .overflow_o(overflow), .busy_o(busy),
    .uart_tx_o(uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] db;
    logic [1:0] par;
    logic       s2;
    int         div;
    string      frm;   // expected line, one char per bit in send order
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string bs(input logic b);
    return b ? "1" : "0";
  endfunction

  // Reference frame: start, N data bits LSB first, optional parity, stops.
  function automatic string build_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] par, input logic s2);
    string s;
    int    n, ones;
    n = 5 + int'(db);
    s = "0";
    ones = 0;
    for (int i = 0; i < n; i++) begin
      s = {s, bs(d[i])};
      ones += int'(d[i]);
    end
    if (par == 2'b01)      s = {s, bs((ones % 2) == 1)};
    else if (par == 2'b10) s = {s, bs((ones % 2) == 0)};
    s = {s, "1"};
    if (s2) s = {s, "1"};
    return s;
  endfunction

  // Checks the line every clock: each bit must hold exactly div+1 clocks.
  task automatic wave(input string nm, input string s, input int div);
    for (int b = 0; b < s.len(); b++)
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        chk(nm, {31'd0, uart_tx}, {31'd0, s[b] == "1"});
      end
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] par,
                         input logic s2, input int div);
    data_bits = db;
    parity    = par;
    stop2     = s2;
    baud_div  = DIV_W'(div);
  endtask

  vec_t tbl[6];
  logic [7:0] expq[$];

  initial begin
    rst = 1'b1; data_write = 1'b0; data = '0; full_thres = '0;
    set_cfg(2'b11, 2'b00, 1'b0, 0);

    tbl[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 3, "0101001011"};
    tbl[1] = '{8'h03, 2'b10, 2'b01, 1'b1, 0, "01100000011"};
    tbl[2] = '{8'h07, 2'b10, 2'b01, 1'b1, 0, "01110000111"};
    tbl[3] = '{8'hFF, 2'b00, 2'b10, 1'b0, 1, "01111101"};
    tbl[4] = '{8'h3C, 2'b11, 2'b10, 1'b1, 2, "000111100111"};
    tbl[5] = '{8'h2A, 2'b01, 2'b11, 1'b0, 1, "00101011"};

    // Reset state
    #3;
    chk("rst_tx", {31'd0, uart_tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_level", {27'd0, fifo_level}, 0);
    chk("rst_full", {31'd0, fifo_full}, 0);
    chk("rst_dbf_thr0", {31'd0, data_buffer_full}, 1);
    full_thres = 5'd12;
    #1;
    chk("rst_dbf_thr12", {31'd0, data_buffer_full}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed frame table
    foreach (tbl[i]) begin
      set_cfg(tbl[i].db, tbl[i].par, tbl[i].s2, tbl[i].div);
      data = tbl[i].d;
      data_write = 1'b1;
      step();
      data_write = 1'b0;
      @(negedge clk);
      chk("tbl_level1", {27'd0, fifo_level}, 1);
      chk("tbl_idle_before_start", {31'd0, uart_tx}, 1);
      wave($sformatf("tbl%0d_line", i), tbl[i].frm, tbl[i].div);
      @(negedge clk);
      chk("tbl_busy_after", {31'd0, busy}, 0);
      chk("tbl_line_after", {31'd0, uart_tx}, 1);
      step();
    end

    // FIFO fill, thresholds, overflow and write coinciding with a pop
    begin
      int fr, e;
      fr = 10 * 101;
      set_cfg(2'b11, 2'b00, 1'b0, 100);
      full_thres = 5'd12;
      data = 8'h00;
      data_write = 1'b1;
      step();
      data_write = 1'b0;
      step();               // this edge starts the first frame
      e = 0;
      data_write = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        step(); e++;
        @(negedge clk);
        chk($sformatf("fill_level%0d", i), {27'd0, fifo_level}, i);
        chk($sformatf("fill_dbf%0d", i), {31'd0, data_buffer_full}, (i >= 12) ? 1 : 0);
        chk($sformatf("fill_full%0d", i), {31'd0, fifo_full}, (i == 16) ? 1 : 0);
        chk("fill_no_ovf", {31'd0, overflow}, 0);
      end
      step(); e++;
      @(negedge clk);
      chk("ovf_pulse", {31'd0, overflow}, 1);
      chk("ovf_level", {27'd0, fifo_level}, 16);
      data_write = 1'b0;
      full_thres = 5'd17;
      #1;
      chk("dbf_thr_above_depth", {31'd0, data_buffer_full}, 0);
      full_thres = 5'd16;
      #1;
      chk("dbf_thr_eq_depth", {31'd0, data_buffer_full}, 1);
      full_thres = 5'd12;
      step(); e++;
      @(negedge clk);
      chk("ovf_cleared", {31'd0, overflow}, 0);
      chk("ovf_level_hold", {27'd0, fifo_level}, 16);
      while (e < fr - 1) begin step(); e++; end
      data_write = 1'b1;
      step();               // frame end: pop and push together
      data_write = 1'b0;
      @(negedge clk);
      chk("full_pushpop_level", {27'd0, fifo_level}, 16);
      chk("full_pushpop_no_ovf", {31'd0, overflow}, 0);
      chk("full_pushpop_busy", {31'd0, busy}, 1);

      // Reset in the middle of DATA (data bits all zero)
      repeat (150) step();
      @(negedge clk);
      chk("mid_data_line_low", {31'd0, uart_tx}, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_line", {31'd0, uart_tx}, 1);
      chk("async_rst_level", {27'd0, fifo_level}, 0);
      chk("async_rst_busy", {31'd0, busy}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        chk("post_rst_idle_line", {31'd0, uart_tx}, 1);
      end
      chk("post_rst_busy", {31'd0, busy}, 0);
    end

    // Three queued frames, parity changed during the first frame
    begin
      string s;
      set_cfg(2'b11, 2'b01, 1'b0, 2);
      s = {build_frame(8'h5A, 2'b11, 2'b01, 1'b0),
           build_frame(8'h5B, 2'b11, 2'b10, 1'b0),
           build_frame(8'h0F, 2'b11, 2'b10, 1'b0)};
      step();
      data = 8'h5A; data_write = 1'b1;
      step();
      data = 8'h5B;
      step();               // first frame starts with even parity
      data = 8'h0F;
      parity = 2'b10;
      fork
        begin step(); data_write = 1'b0; end
      join_none
      wave("contig_line", s, 2);
      @(negedge clk);
      chk("contig_busy_after", {31'd0, busy}, 0);
    end

    // Randomized frames decoded by a sampling receiver
    for (int bt = 0; bt < 8; bt++) begin
      int n, div;
      logic [1:0] db, par;
      logic s2;
      db  = 2'($urandom_range(0, 3));
      par = 2'($urandom_range(0, 3));
      s2  = 1'($urandom_range(0, 1));
      div = $urandom_range(0, 3);
      n   = $urandom_range(1, 6);
      set_cfg(db, par, s2, div);
      step();
      fork
        begin
          for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 12);
            repeat (gap) step();
            data = 8'($urandom);
            expq.push_back(data);
            data_write = 1'b1;
            step();
            data_write = 1'b0;
          end
        end
        begin
          for (int f = 0; f < n; f++) begin
            int cnt, tmo, flen;
            string act, exps;
            logic [7:0] w;
            tmo = 0;
            @(negedge clk);
            while (uart_tx !== 1'b0 && tmo < 2000) begin
              @(negedge clk);
              tmo++;
            end
            if (tmo >= 2000) begin
              chk("rand_start_timeout", 1, 0);
              break;
            end
            w = (expq.size() > 0) ? expq.pop_front() : 8'h00;
            exps = build_frame(w, db, par, s2);
            flen = exps.len();
            act = "";
            cnt = 0;
            for (int b = 0; b < flen; b++) begin
              while (cnt < b * (div + 1) + div / 2) begin
                @(negedge clk);
                cnt++;
              end
              act = {act, bs(uart_tx)};
            end
            chk_s($sformatf("rand%0d_frame%0d", bt, f), act, exps);
          end
        end
      join
      begin
        int tmo;
        tmo = 0;
        while (busy !== 1'b0 && tmo < 500) begin @(negedge clk); tmo++; end
        chk("rand_busy_drops", {31'd0, busy}, 0);
        chk("rand_level_empty", {27'd0, fifo_level}, 0);
      end
      expq.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
